// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: default geometry,
// FSM state encoding and derived index widths.
package systolic_pkg;

    localparam int ARRAY_N   = 4;
    localparam int K_W       = 16;
    localparam int BUF_AW    = 12;
    localparam int ROW_IDX_W = $clog2(ARRAY_N);

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t CLEAR   = 3'd1;
    localparam state_t COMPUTE = 3'd2;
    localparam state_t DRAIN   = 3'd3;
    localparam state_t DONE    = 3'd4;

endpackage

// File: rtl/systolic_skew_gen.sv
// Combinational skew window: lane i is live while operand beats 0..K-1 pass it,
// i.e. for step counts i+1..i+K (one extra cycle for the operand buffer read).
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int N  = ARRAY_N,
    parameter int KW = K_W
) (
    input  logic [KW:0]   t,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  en
);

    // One guard bit above t so k+i cannot overflow the comparison.
    logic [KW+1:0] t_ext;
    logic [KW+1:0] k_ext;

    assign t_ext = {1'b0, t};
    assign k_ext = {2'b00, k};

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [KW+1:0] LO  = (KW+2)'(gi + 1);
        localparam logic [KW+1:0] OFS = (KW+2)'(gi);
        assign en[gi] = (t_ext >= LO) && (t_ext <= k_ext + OFS);
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for the NxN systolic MAC array: clear, stream K beats with
// skewed enables, wait out fill/flush, then hand off N result rows.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = ARRAY_N,
    parameter int KW = K_W,
    parameter int AW = BUF_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_rd_en,
    output logic [AW-1:0]        buf_addr,
    output logic [N-1:0]         row_en,
    output logic [N-1:0]         col_en,
    output logic                 pe_rst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_row
);

    localparam int              RW         = $clog2(N);
    localparam logic [KW:0]     FILL_FLUSH = (KW+1)'(2 * N - 2);
    localparam logic [RW-1:0]   LAST_ROW   = RW'(N - 1);

    state_t          state_reg, state_next;
    logic [KW:0]     t_reg, t_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [RW-1:0]   row_reg, row_next;
    logic [KW:0]     t_last;

    logic [N-1:0]    window;
    logic [N-1:0]    en_next;
    logic            rd_next;
    logic [AW-1:0]   addr_next;

    logic            busy_reg, done_reg, rd_reg, pe_rst_reg, valid_reg;
    logic [AW-1:0]   addr_reg;
    logic [N-1:0]    en_reg;

    // Last COMPUTE step: K beats plus the array fill/flush skew.
    assign t_last = {1'b0, k_reg} + FILL_FLUSH;

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        k_next     = k_reg;
        row_next   = row_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    k_next     = k_len;
                end
            end
            CLEAR: begin
                t_next     = '0;
                row_next   = '0;
                state_next = (k_reg == '0) ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                if (t_reg == t_last) begin
                    state_next = DRAIN;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            DRAIN: begin
                // out_valid is always high here, so a ready is a transfer.
                if (out_ready) begin
                    if (row_reg == LAST_ROW) begin
                        state_next = DONE;
                        row_next   = '0;
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    systolic_skew_gen #(
        .N  (N),
        .KW (KW)
    ) u_skew (
        .t  (t_next),
        .k  (k_next),
        .en (window)
    );

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        rd_next = (state_next == COMPUTE) && (t_next < {1'b0, k_next});
        en_next = (state_next == COMPUTE) ? window : '0;
        if (rd_next) begin
            addr_next = t_next[AW-1:0];
        end else if (state_next == CLEAR) begin
            addr_next = '0;
        end else begin
            addr_next = addr_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            t_reg      <= '0;
            k_reg      <= '0;
            row_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            rd_reg     <= 1'b0;
            addr_reg   <= '0;
            en_reg     <= '0;
            pe_rst_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            t_reg      <= t_next;
            k_reg      <= k_next;
            row_reg    <= row_next;
            busy_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == DONE);
            rd_reg     <= rd_next;
            addr_reg   <= addr_next;
            en_reg     <= en_next;
            pe_rst_reg <= (state_next == CLEAR);
            valid_reg  <= (state_next == DRAIN);
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign buf_rd_en = rd_reg;
    assign buf_addr  = addr_reg;
    assign row_en    = en_reg;
    assign col_en    = en_reg;
    assign pe_rst    = pe_rst_reg;
    assign out_valid = valid_reg;
    assign out_row   = row_reg;

endmodule
